servo_pwm_array: RTL

- Multi-channel successor to the single-servo PWM driver: NCH independent PWM outputs sharing one period counter.
- Each channel takes an arbitrary clamped pulse-width command through a valid/ready port, not a fixed three-level code.
- Width changes commit only at period boundaries and are slew-limited, so pulses never glitch and motors never step abruptly.
- Sits between the command decoder / control FSM and the motor pins.

---
 rtl/servo_pkg.sv | 34 +++
 rtl/servo_pwm_chan.sv | 93 +++++++++
 rtl/servo_pwm_array.sv | 75 +++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared servo timing defaults, the legacy three-level command code and the width clamp.
// Used by servo_pwm_array and servo_pwm_chan.
package servo_pkg;

  localparam int DEF_PERIOD       = 3072;
  localparam int DEF_PW_MIN       = 154;
  localparam int DEF_PW_STOP      = 230;
  localparam int DEF_PW_MAX       = 307;
  localparam int DEF_STEP         = 8;
  localparam int DEF_WDOG_PERIODS = 50;

  // Command code of the original single-servo driver; 2'b00 is not a valid code.
  typedef enum logic [1:0] {
    FWD  = 2'b01,
    BACK = 2'b10,
    STOP = 2'b11
  } legacy_cmd_e;

  function automatic int unsigned legacy_pulse(input legacy_cmd_e c);
    case (c)
      FWD:     return DEF_PW_MAX;
      BACK:    return DEF_PW_MIN;
      default: return DEF_PW_STOP;
    endcase
  endfunction

  function automatic int unsigned clamp(input int unsigned v, input int unsigned lo,
                                        input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: target/active width registers, per-period slew and the PWM compare register.
// Optional per-channel command watchdog under SERVO_PWM_ARRAY_WATCHDOG_EN.
module servo_pwm_chan
  import servo_pkg::*;
#(
  parameter int CNT_W        = 12,
  parameter int PW_STOP      = DEF_PW_STOP,
  parameter int STEP         = DEF_STEP,
  parameter int WDOG_PERIODS = DEF_WDOG_PERIODS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_wr,
  input  logic [CNT_W-1:0] cmd_width,
  input  logic             commit,
  input  logic [CNT_W-1:0] count_next,
  output logic             pwm,
  output logic             wdog_trip
);

  localparam logic [CNT_W:0] STEP_EXT = (CNT_W+1)'(STEP);

  logic [CNT_W-1:0] target_reg, target_next;
  logic [CNT_W-1:0] active_reg, active_next;
  logic [CNT_W-1:0] slewed;
  logic [CNT_W:0]   tgt_ext, act_ext, gap;
  logic             pwm_reg;
  logic             wd_fire;

  // Extra bit keeps the gap and the downward step from wrapping.
  always_comb begin
    tgt_ext = {1'b0, target_reg};
    act_ext = {1'b0, active_reg};
    slewed  = target_reg;
    if (tgt_ext >= act_ext) begin
      gap = tgt_ext - act_ext;
      if (gap > STEP_EXT) slewed = CNT_W'(act_ext + STEP_EXT);
    end else begin
      gap = act_ext - tgt_ext;
      if (gap > STEP_EXT) slewed = CNT_W'(act_ext - STEP_EXT);
    end
    active_next = commit ? slewed : active_reg;
  end

  always_comb begin
    target_next = target_reg;
    if (cmd_wr)       target_next = cmd_width;
    else if (wd_fire) target_next = CNT_W'(PW_STOP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_reg <= CNT_W'(PW_STOP);
      active_reg <= CNT_W'(PW_STOP);
      pwm_reg    <= 1'b0;
    end else begin
      target_reg <= target_next;
      active_reg <= active_next;
      pwm_reg    <= (count_next < active_next);
    end
  end

  assign pwm = pwm_reg;

`ifdef SERVO_PWM_ARRAY_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_PERIODS + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            wd_trip_reg;

  // The counter saturates at WDOG_PERIODS, so the trip fires only once per idle spell.
  assign wd_fire = commit && (wd_cnt_reg == WD_W'(WDOG_PERIODS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_reg  <= '0;
      wd_trip_reg <= 1'b0;
    end else if (cmd_wr) begin
      wd_cnt_reg  <= '0;
      wd_trip_reg <= 1'b0;
    end else if (commit) begin
      if (wd_cnt_reg != WD_W'(WDOG_PERIODS)) wd_cnt_reg <= wd_cnt_reg + 1'b1;
      if (wd_fire) wd_trip_reg <= 1'b1;
    end
  end

  assign wdog_trip = wd_trip_reg;
`else
  assign wd_fire   = 1'b0;
  assign wdog_trip = 1'b0;
`endif

endmodule

// File: rtl/servo_pwm_array.sv
// NCH servo PWM outputs sharing one period counter, with a valid/ready width command port.
// Define SERVO_PWM_ARRAY_WATCHDOG_EN to enable the per-channel command watchdog.
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int CNT_W        = 12,
  parameter int PERIOD       = DEF_PERIOD,
  parameter int PW_MIN       = DEF_PW_MIN,
  parameter int PW_STOP      = DEF_PW_STOP,
  parameter int PW_MAX       = DEF_PW_MAX,
  parameter int STEP         = DEF_STEP,
  parameter int WDOG_PERIODS = DEF_WDOG_PERIODS,
  localparam int CHAN_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CHAN_W-1:0] cmd_chan,
  input  logic [CNT_W-1:0]  cmd_pulse,
  output logic              cmd_err,
  output logic              period_tick,
  output logic [NCH-1:0]    pwm,
  output logic [NCH-1:0]    wdog_trip
);

  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] cmd_width;
  logic [NCH-1:0]   chan_wr;
  logic             commit, accept, chan_bad, cmd_err_reg;

  assign commit      = (count_reg == CNT_W'(PERIOD - 1));
  assign count_next  = commit ? '0 : count_reg + 1'b1;
  assign period_tick = commit;

  // Commands are held off during the commit cycle so a width never changes mid-update.
  assign cmd_ready = !reset && !commit;
  assign accept    = cmd_valid && cmd_ready;
  assign chan_bad  = (32'(cmd_chan) >= NCH);
  assign cmd_width = CNT_W'(clamp(32'(cmd_pulse), PW_MIN, PW_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg   <= '0;
      cmd_err_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      cmd_err_reg <= accept && chan_bad;
    end
  end

  assign cmd_err = cmd_err_reg;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign chan_wr[gi] = accept && (32'(cmd_chan) == gi);

    servo_pwm_chan #(
      .CNT_W        (CNT_W),
      .PW_STOP      (PW_STOP),
      .STEP         (STEP),
      .WDOG_PERIODS (WDOG_PERIODS)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .cmd_wr     (chan_wr[gi]),
      .cmd_width  (cmd_width),
      .commit     (commit),
      .count_next (count_next),
      .pwm        (pwm[gi]),
      .wdog_trip  (wdog_trip[gi])
    );
  end

endmodule
